// File: rtl/bit_packer.sv
// Serial-to-parallel bit packer: accumulates single bits LSB first into a WIDTH-bit word
// presented on a valid/ready port. Optional word_parity output under BIT_PACKER_PARITY_EN.
module bit_packer #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       bit_valid,
  input  logic                       bit_data,
  output logic                       bit_ready,
  input  logic                       flush,
  output logic                       word_valid,
  output logic [WIDTH-1:0]           word_data,
  input  logic                       word_ready,
  output logic [$clog2(WIDTH+1)-1:0] fill_count
`ifdef BIT_PACKER_PARITY_EN
  ,
  output logic                       word_parity
`endif
);

  localparam int FW = $clog2(WIDTH+1);
  localparam logic [FW-1:0] LAST_IDX = FW'(WIDTH - 1);

  logic [WIDTH-1:0] asm_reg;
  logic [WIDTH-1:0] asm_next;
  logic [FW-1:0]    idx_reg;
  logic [WIDTH-1:0] out_reg;
  logic             valid_reg;

  logic at_last;
  logic accept;
  logic complete;
  logic out_free;
  logic do_flush;
  logic load;

  // Stall only when the word being finished would overwrite an undrained out word.
  assign at_last   = (idx_reg == LAST_IDX);
  assign bit_ready = !(at_last && valid_reg && !word_ready);
  assign accept    = bit_valid && bit_ready;
  assign complete  = accept && at_last;
  assign out_free  = !valid_reg || word_ready;
  assign do_flush  = flush && (idx_reg != '0) && !bit_valid && out_free;
  assign load      = complete || do_flush;

  // asm with the incoming bit merged in; positions above idx are already zero,
  // so the same vector serves both completion and flush loads.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_merge
      assign asm_next[gi] = (accept && (idx_reg == FW'(gi))) ? bit_data : asm_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_reg   <= '0;
      idx_reg   <= '0;
      out_reg   <= '0;
      valid_reg <= 1'b0;
    end else if (load) begin
      out_reg   <= asm_next;
      valid_reg <= 1'b1;
      asm_reg   <= '0;
      idx_reg   <= '0;
    end else begin
      if (accept) begin
        asm_reg <= asm_next;
        idx_reg <= idx_reg + FW'(1);
      end
      if (valid_reg && word_ready) begin
        valid_reg <= 1'b0;
      end
    end
  end

`ifdef BIT_PACKER_PARITY_EN
  logic parity_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_reg <= 1'b0;
    end else if (load) begin
      parity_reg <= ^asm_next;
    end
  end

  assign word_parity = parity_reg;
`endif

  assign word_valid = valid_reg;
  assign word_data  = out_reg;
  assign fill_count = idx_reg;

endmodule

// File: tb/tb_bit_packer.sv
// Directed self-checking bench for bit_packer (WIDTH=8): reset, pack, streaming,
// backpressure, flush, async reset and (with BIT_PACKER_PARITY_EN) parity.
module tb_bit_packer;

  logic       clk;
  logic       rst_n;
  logic       bit_valid;
  logic       bit_data;
  logic       bit_ready;
  logic       flush;
  logic       word_valid;
  logic [7:0] word_data;
  logic       word_ready;
  logic [3:0] fill_count;
`ifdef BIT_PACKER_PARITY_EN
  logic       word_parity;
`endif

  int checks;
  int errors;

  bit_packer #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_valid  (bit_valid),
    .bit_data   (bit_data),
    .bit_ready  (bit_ready),
    .flush      (flush),
    .word_valid (word_valid),
    .word_data  (word_data),
    .word_ready (word_ready),
    .fill_count (fill_count)
`ifdef BIT_PACKER_PARITY_EN
    ,
    .word_parity(word_parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives n bits of w, LSB first, one per cycle.
  task automatic send_bits(input logic [7:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      bit_valid = 1'b1;
      bit_data  = w[i];
      step();
    end
    bit_valid = 1'b0;
    bit_data  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bit_valid = 1'b0; bit_data = 1'b0; flush = 1'b0; word_ready = 1'b1;
    #12;
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", word_valid); end
    checks++; if (word_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", word_data); end
    checks++; if (fill_count !== 4'd0) begin errors++; $display("FAIL reset_fill: got %0d expected 0", fill_count); end
    checks++; if (bit_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bit_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    $display("reset: released");
  endtask

  task automatic test_basic_pack();
    word_ready = 1'b1;
    send_bits(8'h9C, 7);
    checks++; if (fill_count !== 4'd7) begin errors++; $display("FAIL basic_fill7: got %0d expected 7", fill_count); end
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b expected 0", word_valid); end
    bit_valid = 1'b1; bit_data = 1'b1;
    step();
    bit_valid = 1'b0; bit_data = 1'b0;
    checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", word_valid); end
    checks++; if (word_data !== 8'h9C) begin errors++; $display("FAIL basic_data: got %h expected 9c", word_data); end
    checks++; if (fill_count !== 4'd0) begin errors++; $display("FAIL basic_fill0: got %0d expected 0", fill_count); end
    step();
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: got %b expected 0", word_valid); end
    $display("basic_pack: word %h", 8'h9C);
  endtask

  task automatic test_back_to_back();
    logic [15:0] stream;
    int          drops;
    stream = 16'h3CA5;
    drops = 0;
    word_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bit_valid = 1'b1;
      bit_data  = stream[i];
      #1;
      if (bit_ready !== 1'b1) drops++;
      step();
      if (i == 7) begin
        checks++; if (word_valid !== 1'b1 || word_data !== 8'hA5) begin errors++; $display("FAIL b2b_word0: got valid=%b data=%h expected valid=1 data=a5", word_valid, word_data); end
      end
    end
    bit_valid = 1'b0;
    checks++; if (word_valid !== 1'b1 || word_data !== 8'h3C) begin errors++; $display("FAIL b2b_word1: got valid=%b data=%h expected valid=1 data=3c", word_valid, word_data); end
    checks++; if (drops !== 0) begin errors++; $display("FAIL b2b_ready_drops: got %0d expected 0", drops); end
    step();
    $display("back_to_back: words a5 3c");
  endtask

  task automatic test_backpressure();
    word_ready = 1'b0;
    send_bits(8'h81, 8);
    checks++; if (word_valid !== 1'b1 || word_data !== 8'h81) begin errors++; $display("FAIL bp_word0: got valid=%b data=%h expected valid=1 data=81", word_valid, word_data); end
    send_bits(8'hE7, 7);
    checks++; if (fill_count !== 4'd7) begin errors++; $display("FAIL bp_fill7: got %0d expected 7", fill_count); end
    bit_valid = 1'b1; bit_data = 1'b1;
    #1;
    checks++; if (bit_ready !== 1'b0) begin errors++; $display("FAIL bp_stall: got %b expected 0", bit_ready); end
    step();
    checks++; if (fill_count !== 4'd7 || word_data !== 8'h81) begin errors++; $display("FAIL bp_hold: got fill=%0d data=%h expected fill=7 data=81", fill_count, word_data); end
    word_ready = 1'b1;
    #1;
    checks++; if (bit_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got %b expected 1", bit_ready); end
    step();
    bit_valid = 1'b0; bit_data = 1'b0;
    checks++; if (word_valid !== 1'b1 || word_data !== 8'hE7 || fill_count !== 4'd0) begin errors++; $display("FAIL bp_word1: got valid=%b data=%h fill=%0d expected valid=1 data=e7 fill=0", word_valid, word_data, fill_count); end
    step();
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b expected 0", word_valid); end
    $display("backpressure: words 81 e7");
  endtask

  task automatic test_flush();
    word_ready = 1'b1;
    send_bits(8'h05, 3);
    checks++; if (fill_count !== 4'd3) begin errors++; $display("FAIL flush_fill3: got %0d expected 3", fill_count); end
    flush = 1'b1;
    step();
    checks++; if (word_valid !== 1'b1 || word_data !== 8'h05 || fill_count !== 4'd0) begin errors++; $display("FAIL flush_word: got valid=%b data=%h fill=%0d expected valid=1 data=05 fill=0", word_valid, word_data, fill_count); end
    step();
    checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL flush_empty: got %b expected 0", word_valid); end
    flush = 1'b0;
    send_bits(8'h03, 2);
    flush = 1'b1; bit_valid = 1'b1; bit_data = 1'b0;
    step();
    checks++; if (word_valid !== 1'b0 || fill_count !== 4'd3) begin errors++; $display("FAIL flush_deferred: got valid=%b fill=%0d expected valid=0 fill=3", word_valid, fill_count); end
    bit_valid = 1'b0;
    step();
    checks++; if (word_valid !== 1'b1 || word_data !== 8'h03) begin errors++; $display("FAIL flush_after_bit: got valid=%b data=%h expected valid=1 data=03", word_valid, word_data); end
    flush = 1'b0;
    step();
    $display("flush: words 05 03");
  endtask

  task automatic test_async_reset();
    word_ready = 1'b0;
    send_bits(8'h55, 8);
    send_bits(8'h1F, 5);
    checks++; if (fill_count !== 4'd5 || word_valid !== 1'b1) begin errors++; $display("FAIL areset_pre: got fill=%0d valid=%b expected fill=5 valid=1", fill_count, word_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (word_valid !== 1'b0 || fill_count !== 4'd0 || word_data !== 8'h00) begin errors++; $display("FAIL areset_immediate: got valid=%b fill=%0d data=%h expected valid=0 fill=0 data=00", word_valid, fill_count, word_data); end
    @(negedge clk);
    rst_n = 1'b1;
    word_ready = 1'b1;
    step();
    send_bits(8'h3A, 8);
    checks++; if (word_valid !== 1'b1 || word_data !== 8'h3A) begin errors++; $display("FAIL areset_clean: got valid=%b data=%h expected valid=1 data=3a", word_valid, word_data); end
    step();
    $display("async_reset: clean word 3a");
  endtask

`ifdef BIT_PACKER_PARITY_EN
  task automatic test_parity();
    word_ready = 1'b1;
    send_bits(8'h01, 8);
    checks++; if (word_data !== 8'h01 || word_parity !== 1'b1) begin errors++; $display("FAIL parity_01: got data=%h parity=%b expected data=01 parity=1", word_data, word_parity); end
    send_bits(8'h03, 8);
    checks++; if (word_data !== 8'h03 || word_parity !== 1'b0) begin errors++; $display("FAIL parity_03: got data=%h parity=%b expected data=03 parity=0", word_data, word_parity); end
    step();
    $display("parity: words 01 03");
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic_pack();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_async_reset();
`ifdef BIT_PACKER_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
